imem_load_ctrl: RTL and testbench
=================================

// Module: imem_load_ctrl
// PURPOSE
//  Owns the single port of the 256x32 instruction memory and time-shares it between the
//  core fetch path and a boot/reload write stream. Holds the core stalled until a program
//  image is fully written, then serves fetches with a registered read (1-cycle latency).
//  Sits between the PC/fetch stage and the instruction memory array.
// PARAMETERS
//  ADDR_W   8    word-index width; memory depth = 2**ADDR_W words
//  DATA_W   32   instruction width
// PORTS
//  clk          in   1         single clock, all logic rising-edge
//  rst_n        in   1         reset, synchronous, active-low
//  load_start   in   1         pulse: begin loading image (ignored while in LOAD)
//  load_len     in   ADDR_W+1  words to load, sampled with load_start
//  ld_valid     in   1         load stream word valid
//  ld_data      in   DATA_W    load stream word
//  ld_ready     out  1         controller accepts word this cycle
//  load_done    out  1         1-cycle pulse when image complete
//  core_stall   out  1         core must hold PC / not issue fetch
//  fetch_req    in   1         fetch request (honoured only in RUN)
//  fetch_addr   in   32        byte PC
//  fetch_valid  out  1         fetch_rdata/fetch_err valid (1 cycle after accepted req)
//  fetch_rdata  out  DATA_W    fetched instruction
//  fetch_err    out  1         misaligned fetch (fetch_addr[1:0]!=0)
//  mem_we       out  1         memory write enable
//  mem_addr     out  ADDR_W    memory word index (write or read)
//  mem_wdata    out  DATA_W    memory write data
//  mem_rdata    in   DATA_W    memory read data, combinational from mem_addr
// BEHAVIOUR
//  FSM: IDLE -> LOAD -> RUN; RUN -> LOAD on load_start.
//  Reset (rst_n=0 at edge): state=IDLE, word counter=0; all outputs 0 except core_stall=1.
//   Reset mid-load aborts the load; already-written words are not cleared.
//  IDLE: core_stall=1, ld_ready=0; load_start -> LOAD, latch len=min(load_len, 2**ADDR_W).
//  LOAD: core_stall=1, ld_ready=1. Write when ld_valid&ld_ready: mem_we=1,
//   mem_addr=counter, mem_wdata=ld_data, counter++ (combinational drive, same cycle).
//   Write of word len-1 -> RUN next cycle, load_done=1 in that cycle (registered pulse).
//   len==0 -> LOAD for exactly one cycle, no writes, then RUN with load_done.
//   ld_valid gaps stall the counter; load_start while in LOAD is ignored.
//  RUN: core_stall=0, ld_ready=0. fetch_req: mem_addr=fetch_addr[ADDR_W+1:2],
//   mem_rdata registered; next cycle fetch_valid=1, fetch_rdata=word, fetch_err=0.
//   Back-to-back fetch_req every cycle -> one fetch_valid per cycle, fully pipelined.
//   Misaligned addr: no memory read used; next cycle fetch_valid=1, fetch_err=1, rdata=0.
//   Address bits above ADDR_W+1 ignored (index aliases modulo depth).
//   load_start && fetch_req same cycle: load wins, fetch dropped (no fetch_valid),
//   core_stall=1 from the next cycle, counter restarts at 0.
//  fetch_req outside RUN is ignored; fetch_valid is 0 whenever not responding.
//  mem_we=0 in all states except an accepted LOAD write; mem_addr=0 when unused.
// TESTING
//  1 Reset then load_start,len=3, words 0x00A00093,0x01400113,0x02800193 back-to-back
//    -> writes idx 0,1,2; load_done one cycle after idx 2; core_stall falls same cycle.
//  2 RUN, fetch_req addr 0x0,0x4,0x8 consecutive -> fetch_valid 3 cycles, rdata in order,
//    each 1 cycle after its req.
//  3 LOAD with ld_valid toggling 1,0,0,1 for len=2 -> only 2 writes, idx 0 then 1, no skips.
//  4 fetch_addr=0x6 -> next cycle fetch_valid=1, fetch_err=1, fetch_rdata=0.
//  5 RUN, load_start+fetch_req same cycle (len=1) -> no fetch_valid, core_stall=1,
//    one write to idx 0, then RUN; also len=0 -> load_done after 1 LOAD cycle.
//  6 rst_n=0 after 2 of 4 words -> IDLE, core_stall=1; reload len=4 restarts at idx 0;
//    load_len=300 clamps to 256 words, last write idx 255.

Source files
------------

// File: rtl/imem_load_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : imem_load_ctrl_if
//  Description : Bundle of the load stream, the core fetch path and the
//                single-port instruction-memory bus around imem_load_ctrl.
//                slave  : the controller side.
//                master : the environment side (load source, fetch stage,
//                         memory array).
//  Signals     : load_start/load_len        image load command
//                ld_valid/ld_data/ld_ready  load word stream
//                load_done/core_stall       load status towards the core
//                fetch_req/fetch_addr       fetch request (byte PC)
//                fetch_valid/rdata/err      fetch response, 1 cycle later
//                mem_we/addr/wdata/rdata    memory port, rdata combinational
//  Revision    : 1.0  initial release
// ============================================================================
interface imem_load_ctrl_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   logic              load_start;
   logic [ADDR_W:0]   load_len;
   logic              ld_valid;
   logic [DATA_W-1:0] ld_data;
   logic              ld_ready;
   logic              load_done;
   logic              core_stall;
   logic              fetch_req;
   logic [31:0]       fetch_addr;
   logic              fetch_valid;
   logic [DATA_W-1:0] fetch_rdata;
   logic              fetch_err;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  load_start, load_len, ld_valid, ld_data, fetch_req, fetch_addr, mem_rdata,
      output ld_ready, load_done, core_stall, fetch_valid, fetch_rdata, fetch_err,
             mem_we, mem_addr, mem_wdata
   );

   modport master (
      output load_start, load_len, ld_valid, ld_data, fetch_req, fetch_addr, mem_rdata,
      input  ld_ready, load_done, core_stall, fetch_valid, fetch_rdata, fetch_err,
             mem_we, mem_addr, mem_wdata
   );
endinterface
`default_nettype wire

// File: rtl/imem_load_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : imem_load_ctrl
//  Description : Owns the single port of the instruction memory and shares it
//                between a boot/reload write stream and the core fetch path.
//                The core is stalled until the whole image is written; fetches
//                are then served with a registered read (1-cycle latency).
//  Ports       : clk    rising-edge clock
//                rst_n  synchronous active-low reset
//                bus    imem_load_ctrl_if.slave (load stream, fetch, memory)
//  Revision    : 1.0  initial release
// ============================================================================
module imem_load_ctrl #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   imem_load_ctrl_if.slave  bus
);

   localparam logic [1:0] c_idle = 2'd0;
   localparam logic [1:0] c_load = 2'd1;
   localparam logic [1:0] c_run  = 2'd2;

   localparam logic [ADDR_W:0] c_depth = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] c_one   = {{ADDR_W{1'b0}}, 1'b1};

   logic [1:0]        r_state;
   logic [ADDR_W:0]   r_cnt;
   logic [ADDR_W:0]   r_len;
   logic              r_done;
   logic              r_fvalid;
   logic              r_ferr;
   logic [DATA_W-1:0] r_frdata;

   logic              w_in_idle;
   logic              w_in_load;
   logic              w_in_run;
   logic              w_ld_ready;
   logic              w_wr;
   logic              w_last;
   logic              w_fetch;
   logic              w_misal;
   logic [ADDR_W-1:0] w_fidx;
   logic [ADDR_W:0]   w_len_clamped;
   logic [ADDR_W-1:0] w_mem_addr;
   logic              w_unused;

   assign w_in_idle = (r_state == c_idle);
   assign w_in_load = (r_state == c_load);
   assign w_in_run  = (r_state == c_run);

   // Ready drops for a zero-length image so a word offered during that single
   // LOAD cycle is not consumed without being written.
   assign w_ld_ready = w_in_load && (r_cnt != r_len);
   assign w_wr       = w_ld_ready && bus.ld_valid;
   assign w_last     = w_wr && (r_cnt == (r_len - c_one));

   // A reload request in the same cycle takes priority over a fetch.
   assign w_fetch = w_in_run && bus.fetch_req && !bus.load_start;
   assign w_misal = (bus.fetch_addr[1:0] != 2'b00);
   // Upper PC bits are dropped: the index aliases modulo the memory depth.
   assign w_fidx  = bus.fetch_addr[ADDR_W+1:2];
   assign w_unused = ^{bus.fetch_addr[31:ADDR_W+2]};

   assign w_len_clamped = (bus.load_len > c_depth) ? c_depth : bus.load_len;

   // Memory index is parked at 0 whenever the port is idle or the fetch is
   // misaligned (its read data is never used).
   always_comb begin
      w_mem_addr = '0;
      if (w_wr) begin
         w_mem_addr = r_cnt[ADDR_W-1:0];
      end else if (w_fetch && !w_misal) begin
         w_mem_addr = w_fidx;
      end
   end

   assign bus.mem_addr    = w_mem_addr;
   assign bus.mem_we      = w_wr;
   assign bus.mem_wdata   = w_wr ? bus.ld_data : '0;
   assign bus.ld_ready    = w_ld_ready;
   assign bus.core_stall  = !w_in_run;
   assign bus.load_done   = r_done;
   assign bus.fetch_valid = r_fvalid;
   assign bus.fetch_err   = r_ferr;
   assign bus.fetch_rdata = r_frdata;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= c_idle;
         r_cnt    <= '0;
         r_len    <= '0;
         r_done   <= 1'b0;
         r_fvalid <= 1'b0;
         r_ferr   <= 1'b0;
         r_frdata <= '0;
      end else begin
         r_done   <= 1'b0;
         r_fvalid <= w_fetch;
         r_ferr   <= w_fetch && w_misal;
         r_frdata <= (w_fetch && !w_misal) ? bus.mem_rdata : '0;

         case (r_state)
            c_idle: begin
               if (bus.load_start) begin
                  r_state <= c_load;
                  r_len   <= w_len_clamped;
                  r_cnt   <= '0;
               end
            end
            c_load: begin
               if (r_len == '0) begin
                  r_state <= c_run;
                  r_done  <= 1'b1;
               end else if (w_wr) begin
                  r_cnt <= r_cnt + c_one;
                  if (w_last) begin
                     r_state <= c_run;
                     r_done  <= 1'b1;
                  end
               end
            end
            c_run: begin
               if (bus.load_start) begin
                  r_state <= c_load;
                  r_len   <= w_len_clamped;
                  r_cnt   <= '0;
               end
            end
            default: begin
               r_state <= c_idle;
            end
         endcase

         if (!(w_in_idle || w_in_load || w_in_run)) begin
            r_cnt <= '0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_imem_load_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_load_ctrl
//  Description : Self-checking bench for imem_load_ctrl. Acts as the memory
//                array, the load source and the fetch stage; expected values
//                come from a word-array model of the image contents.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_imem_load_ctrl;

   logic clk;
   logic rst_n;

   imem_load_ctrl_if #(.ADDR_W(8), .DATA_W(32)) bus ();

   imem_load_ctrl #(.ADDR_W(8), .DATA_W(32)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory array behind the controller's single port.
   logic [31:0] mem_arr [0:255];
   always @(posedge clk) begin
      if (bus.mem_we) mem_arr[bus.mem_addr] <= bus.mem_wdata;
   end
   assign bus.mem_rdata = mem_arr[bus.mem_addr];

   // Reference model: what each word of memory should hold.
   logic [31:0] model_mem [0:255];
   int          hi_written;
   logic [31:0] fixed_q [$];

   int   total;
   int   bad;
   bit   p_req;
   logic [31:0] p_addr;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One RUN cycle: drive a request, check the response to the previous one.
   task automatic fcycle(input bit req, input logic [31:0] addr);
      logic exp_err;
      bus.fetch_req  = req;
      bus.fetch_addr = addr;
      #1;
      chk("fetch_valid", 64'(bus.fetch_valid), 64'(p_req));
      if (p_req) begin
         exp_err = (p_addr[1:0] != 2'b00);
         chk("fetch_err", 64'(bus.fetch_err), 64'(exp_err));
         chk("fetch_rdata", 64'(bus.fetch_rdata), exp_err ? 64'd0 : 64'(model_mem[p_addr[9:2]]));
      end
      chk("run_stall", 64'(bus.core_stall), 64'd0);
      chk("run_we", 64'(bus.mem_we), 64'd0);
      chk("run_done", 64'(bus.load_done), 64'd0);
      chk("run_ready", 64'(bus.ld_ready), 64'd0);
      chk("fetch_mem_addr", 64'(bus.mem_addr),
          (req && addr[1:0] == 2'b00) ? 64'(addr[9:2]) : 64'd0);
      p_req  = req;
      p_addr = addr;
      tick();
   endtask

   // Random fetch traffic over words known to be written.
   task automatic rand_fetches(input int n);
      logic [31:0] a;
      int          idx;
      bit          mis;
      for (int i = 0; i < n; i++) begin
         idx = $urandom_range(hi_written - 1);
         mis = ($urandom_range(7) == 0);
         a   = ($urandom & 32'hFFFF_FC00) | (32'(idx) << 2);
         if (mis) a = a | 32'($urandom_range(1, 3));
         fcycle(($urandom_range(3) != 0), a);
      end
      fcycle(1'b0, 32'h0);
   endtask

   // mode 0: ld_valid every cycle; 1: valid pattern 1,0,0 repeating;
   // 2: random gaps plus ignored load_start/fetch_req noise during LOAD.
   task automatic do_load(input int len_in, input int mode, input bit fetch_same, input bit in_run);
      int          eff;
      int          idx;
      int          cyc;
      bit          v;
      logic [31:0] d;
      bus.load_start = 1'b1;
      bus.load_len   = 9'(len_in);
      bus.fetch_req  = fetch_same;
      bus.fetch_addr = 32'h4;
      #1;
      chk("start_stall", 64'(bus.core_stall), 64'(!in_run));
      chk("start_we", 64'(bus.mem_we), 64'd0);
      chk("start_mem_addr", 64'(bus.mem_addr), 64'd0);
      tick();
      bus.load_start = 1'b0;
      bus.fetch_req  = 1'b0;
      eff = (len_in > 256) ? 256 : len_in;
      if (eff == 0) begin
         bus.ld_valid = 1'b0;
         #1;
         chk("len0_stall", 64'(bus.core_stall), 64'd1);
         chk("len0_we", 64'(bus.mem_we), 64'd0);
         chk("len0_done", 64'(bus.load_done), 64'd0);
         chk("len0_fvalid", 64'(bus.fetch_valid), 64'd0);
         tick();
      end else begin
         idx = 0;
         cyc = 0;
         while (idx < eff && cyc < eff * 4 + 16) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : ($urandom_range(3) != 0);
            d = (fixed_q.size() > 0 && v) ? fixed_q.pop_front() : $urandom;
            bus.ld_valid = v;
            bus.ld_data  = d;
            if (mode == 2) begin
               bus.load_start = 1'($urandom_range(1));
               bus.load_len   = 9'($urandom);
               bus.fetch_req  = 1'($urandom_range(1));
               bus.fetch_addr = $urandom;
            end
            #1;
            chk("load_ready", 64'(bus.ld_ready), 64'd1);
            chk("load_stall", 64'(bus.core_stall), 64'd1);
            chk("load_done_early", 64'(bus.load_done), 64'd0);
            chk("load_fvalid", 64'(bus.fetch_valid), 64'd0);
            chk("load_we", 64'(bus.mem_we), 64'(v));
            if (v) begin
               chk("load_idx", 64'(bus.mem_addr), 64'(idx));
               chk("load_wdata", 64'(bus.mem_wdata), 64'(d));
               model_mem[idx] = d;
               idx++;
            end else begin
               chk("gap_mem_addr", 64'(bus.mem_addr), 64'd0);
            end
            tick();
            cyc++;
         end
         chk("load_budget", 64'(idx), 64'(eff));
      end
      bus.ld_valid   = 1'b0;
      bus.load_start = 1'b0;
      bus.fetch_req  = 1'b0;
      bus.load_len   = '0;
      #1;
      chk("done_pulse", 64'(bus.load_done), 64'd1);
      chk("done_stall", 64'(bus.core_stall), 64'd0);
      chk("done_ready", 64'(bus.ld_ready), 64'd0);
      chk("done_we", 64'(bus.mem_we), 64'd0);
      chk("done_fvalid", 64'(bus.fetch_valid), 64'd0);
      if (eff > hi_written) hi_written = eff;
      p_req = 1'b0;
      tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      total          = 0;
      bad            = 0;
      hi_written     = 0;
      p_req          = 1'b0;
      p_addr         = '0;
      rst_n          = 1'b0;
      bus.load_start = 1'b0;
      bus.load_len   = '0;
      bus.ld_valid   = 1'b0;
      bus.ld_data    = '0;
      bus.fetch_req  = 1'b0;
      bus.fetch_addr = '0;
      tick();
      tick();
      chk("rst_stall", 64'(bus.core_stall), 64'd1);
      chk("rst_ready", 64'(bus.ld_ready), 64'd0);
      chk("rst_done", 64'(bus.load_done), 64'd0);
      chk("rst_fvalid", 64'(bus.fetch_valid), 64'd0);
      chk("rst_ferr", 64'(bus.fetch_err), 64'd0);
      chk("rst_rdata", 64'(bus.fetch_rdata), 64'd0);
      chk("rst_we", 64'(bus.mem_we), 64'd0);
      chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
      rst_n = 1'b1;

      // Three-word program, back-to-back.
      fixed_q = '{32'h00A00093, 32'h01400113, 32'h02800193};
      do_load(3, 0, 1'b0, 1'b0);

      // Consecutive fetches of the three words.
      fcycle(1'b1, 32'h0);
      fcycle(1'b1, 32'h4);
      fcycle(1'b1, 32'h8);
      fcycle(1'b0, 32'h0);
      chk("prog_word2", 64'(model_mem[2]), 64'h02800193);

      // Reload with ld_valid 1,0,0,1 for two words.
      do_load(2, 1, 1'b0, 1'b1);
      fcycle(1'b1, 32'h0);
      fcycle(1'b1, 32'h4);
      fcycle(1'b1, 32'h8);
      // Misaligned fetch.
      fcycle(1'b1, 32'h6);
      fcycle(1'b0, 32'h0);

      // Load wins over a same-cycle fetch; then an empty image.
      do_load(1, 0, 1'b1, 1'b1);
      fcycle(1'b1, 32'h0);
      fcycle(1'b0, 32'h0);
      do_load(0, 0, 1'b0, 1'b1);
      fcycle(1'b1, 32'h8);
      fcycle(1'b0, 32'h0);

      // Random image with gaps and ignored noise, then random fetches.
      do_load(5 + $urandom_range(20), 2, 1'b0, 1'b1);
      rand_fetches(60);

      // Reset after two of four words.
      bus.load_start = 1'b1;
      bus.load_len   = 9'd4;
      tick();
      bus.load_start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus.ld_valid = 1'b1;
         bus.ld_data  = $urandom;
         #1;
         chk("part_idx", 64'(bus.mem_addr), 64'(i));
         model_mem[i] = bus.ld_data;
         tick();
      end
      bus.ld_valid = 1'b0;
      rst_n        = 1'b0;
      tick();
      chk("mid_rst_stall", 64'(bus.core_stall), 64'd1);
      chk("mid_rst_ready", 64'(bus.ld_ready), 64'd0);
      chk("mid_rst_we", 64'(bus.mem_we), 64'd0);
      rst_n          = 1'b1;
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 32'h0;
      #1;
      chk("idle_stall", 64'(bus.core_stall), 64'd1);
      chk("idle_mem_addr", 64'(bus.mem_addr), 64'd0);
      tick();
      bus.fetch_req = 1'b0;
      chk("idle_fvalid", 64'(bus.fetch_valid), 64'd0);
      do_load(4, 0, 1'b0, 1'b0);
      rand_fetches(20);

      // Oversized length clamps to the full depth.
      do_load(300, 2, 1'b0, 1'b1);
      chk("clamp_extent", 64'(hi_written), 64'd256);
      fcycle(1'b1, 32'h3FC);
      fcycle(1'b1, 32'hFFFF_F3FC);
      fcycle(1'b0, 32'h0);
      rand_fetches(300);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
